// File: rtl/count_display_driver_if.sv
// Display-side bus for count_display_driver: binary value in, segment/anode drive out.
interface count_display_driver_if;
    logic [11:0] count;
    logic [6:0]  seg;
    logic [3:0]  an;
    logic        dp;
    logic        busy;

    modport master (output count, input seg, an, dp, busy);
    modport slave  (input count, output seg, an, dp, busy);
endinterface

// File: rtl/count_display_driver.sv
// Converts the 12-bit counter value to BCD with a sequential double-dabble and
// time-multiplexes the four digits onto a common-anode seven-segment display.
module count_display_driver #(
    parameter int unsigned REFRESH_BITS = 18,
    parameter bit          BLANK_LZ     = 1'b0
) (
    input logic                   clk,
    input logic                   rst,
    count_display_driver_if.slave bus
);
    localparam int unsigned BIN_W  = 12;
    localparam int unsigned BCD_W  = 16;
    localparam int unsigned SR_W   = BCD_W + BIN_W;
    localparam int unsigned STEP_W = 4;
    localparam int unsigned DIGITS = 4;
    localparam int unsigned SEG_W  = 7;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_t;

    state_t              state, state_next;
    logic [SR_W-1:0]     sreg, sreg_next;
    logic [STEP_W-1:0]   step, step_next;
    logic [BIN_W-1:0]    cap_val, cap_next;
    logic [BIN_W-1:0]    last_val, last_next;
    logic [BCD_W-1:0]    bcd_reg, bcd_next;
    logic [BCD_W-1:0]    adj;
    logic                busy_q, busy_next;

    logic [REFRESH_BITS-1:0] refresh;
    logic [1:0]              sel;
    logic [3:0]              digit;
    logic [DIGITS-1:0]       lead_zero;
    logic                    blank;
    logic [SEG_W-1:0]        seg_q, seg_next;
    logic [DIGITS-1:0]       an_q, an_next;

    function automatic logic [SEG_W-1:0] decode(input logic [3:0] nib);
        logic [SEG_W-1:0] s;
        case (nib)
            4'd0:    s = 7'b1000000;
            4'd1:    s = 7'b1111001;
            4'd2:    s = 7'b0100100;
            4'd3:    s = 7'b0110000;
            4'd4:    s = 7'b0011001;
            4'd5:    s = 7'b0010010;
            4'd6:    s = 7'b0000010;
            4'd7:    s = 7'b1111000;
            4'd8:    s = 7'b0000000;
            4'd9:    s = 7'b0010000;
            default: s = 7'b1111111;
        endcase
        return s;
    endfunction

    // Add-3 correction of every BCD nibble that is 5 or more, ahead of the shift
    always_comb begin
        adj = sreg[SR_W-1:BIN_W];
        for (int i = 0; i < int'(DIGITS); i++) begin
            if (adj[i*4 +: 4] >= 4'd5) begin
                adj[i*4 +: 4] = adj[i*4 +: 4] + 4'd3;
            end
        end
    end

    // Conversion state and registered conversion results
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= IDLE;
            sreg     <= '0;
            step     <= '0;
            cap_val  <= '0;
            last_val <= '0;
            bcd_reg  <= '0;
            busy_q   <= 1'b0;
        end else begin
            state    <= state_next;
            sreg     <= sreg_next;
            step     <= step_next;
            cap_val  <= cap_next;
            last_val <= last_next;
            bcd_reg  <= bcd_next;
            busy_q   <= busy_next;
        end
    end

    // Next-state logic; bcd_reg only moves in DONE so digits never show a partial result
    always_comb begin
        state_next = state;
        sreg_next  = sreg;
        step_next  = step;
        cap_next   = cap_val;
        last_next  = last_val;
        bcd_next   = bcd_reg;

        case (state)
            IDLE: begin
                if (bus.count != last_val) begin
                    sreg_next  = {BCD_W'(0), bus.count};
                    cap_next   = bus.count;
                    step_next  = '0;
                    state_next = SHIFT;
                end
            end
            SHIFT: begin
                sreg_next = {adj, sreg[BIN_W-1:0]} << 1;
                step_next = step + STEP_W'(1);
                if (step == STEP_W'(BIN_W - 1)) begin
                    state_next = DONE;
                end
            end
            DONE: begin
                bcd_next   = sreg[SR_W-1:BIN_W];
                last_next  = cap_val;
                state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase

        busy_next = (state_next != IDLE);
    end

    assign sel   = refresh[REFRESH_BITS-1 -: 2];
    assign digit = bcd_reg[{sel, 2'b00} +: 4];

    // A digit is a leading zero when it and every higher digit are zero; ones is never one
    always_comb begin
        lead_zero = '0;
        lead_zero[DIGITS-1] = (bcd_reg[BCD_W-1 -: 4] == 4'd0);
        for (int i = int'(DIGITS) - 2; i >= 1; i--) begin
            lead_zero[i] = lead_zero[i+1] && (bcd_reg[i*4 +: 4] == 4'd0);
        end
    end

    assign blank    = BLANK_LZ && lead_zero[sel];
    assign seg_next = blank ? 7'b1111111 : decode(digit);
    assign an_next  = ~(DIGITS'(1) << sel);

    // Refresh scan: anode and segment pattern are registered on the same edge
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            refresh <= '0;
            seg_q   <= 7'b1111111;
            an_q    <= 4'b1111;
        end else begin
            refresh <= refresh + REFRESH_BITS'(1);
            seg_q   <= seg_next;
            an_q    <= an_next;
        end
    end

    assign bus.seg  = seg_q;
    assign bus.an   = an_q;
    assign bus.dp   = 1'b1;
    assign bus.busy = busy_q;

endmodule
